// File: rtl/window_stack.sv
// LIFO of saved window-pointer values: push on call, pop on return drives
// the restored value and a one-cycle load strobe into the window pointer.
module window_stack #(
  parameter int WP_WIDTH = 3,
  parameter int DEPTH    = 8,
  parameter int SP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WP_WIDTH-1:0] wp_in,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  output logic [WP_WIDTH-1:0] wp_out,
  output logic                wp_load,
  output logic [SP_WIDTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [SP_WIDTH:0] L_DEPTH = (SP_WIDTH+1)'(DEPTH);

  logic [WP_WIDTH-1:0] r_mem [DEPTH];
  logic [SP_WIDTH:0]   r_count;
  logic [WP_WIDTH-1:0] r_wp_out;
  logic                r_wp_load;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_push_only;
  logic                w_pop_only;
  logic                w_both;
  logic [SP_WIDTH-1:0] w_wr_idx;
  logic [SP_WIDTH-1:0] w_rd_idx;

  assign w_full      = (r_count == L_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_push_only = push & ~pop & ~flush;
  assign w_pop_only  = pop & ~push & ~flush;
  assign w_both      = push & pop & ~flush;
  assign w_wr_idx    = r_count[SP_WIDTH-1:0];
  assign w_rd_idx    = w_wr_idx - SP_WIDTH'(1);

  // Storage carries no reset; only the occupancy count defines validity.
  always_ff @(negedge clk) begin
    if (reset_n && w_push_only && !w_full) begin
      r_mem[w_wr_idx] <= wp_in;
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_wp_out    <= '0;
      r_wp_load   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_count     <= '0;
      r_wp_load   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_both) begin
      // A call returned immediately forwards wp_in; the stack is untouched.
      r_wp_out  <= wp_in;
      r_wp_load <= 1'b1;
    end else if (w_push_only) begin
      r_wp_load <= 1'b0;
      if (!w_full) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_pop_only) begin
      if (!w_empty) begin
        r_wp_out  <= r_mem[w_rd_idx];
        r_count   <= r_count - 1'b1;
        r_wp_load <= 1'b1;
      end else begin
        r_wp_load   <= 1'b0;
        r_underflow <= 1'b1;
      end
    end else begin
      r_wp_load <= 1'b0;
    end
  end

  assign wp_out    = r_wp_out;
  assign wp_load   = r_wp_load;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_window_stack.sv
// Bench for window_stack: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_window_stack;

  localparam int WP_WIDTH = 3;
  localparam int DEPTH    = 8;
  localparam int SP_WIDTH = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [WP_WIDTH-1:0] wp_in = '0;
  logic                push = 1'b0;
  logic                pop = 1'b0;
  logic                flush = 1'b0;
  logic [WP_WIDTH-1:0] wp_out;
  logic                wp_load;
  logic [SP_WIDTH:0]   count;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                underflow;

  window_stack #(.WP_WIDTH(WP_WIDTH), .DEPTH(DEPTH), .SP_WIDTH(SP_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .wp_in(wp_in), .push(push), .pop(pop),
    .flush(flush), .wp_out(wp_out), .wp_load(wp_load), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit done = 1'b0;

  // Reference model
  int m_stk[$];
  int m_out = 0;
  int m_load = 0;
  int m_ovf = 0;
  int m_unf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_out  = 0;
    m_load = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  task automatic model_update(input bit f, input bit pu, input bit po, input int d);
    if (f) begin
      m_stk.delete();
      m_load = 0; m_ovf = 0; m_unf = 0;
    end else if (pu && po) begin
      m_out = d; m_load = 1;
    end else if (pu) begin
      m_load = 0;
      if (m_stk.size() < DEPTH) m_stk.push_back(d);
      else m_ovf = 1;
    end else if (po) begin
      if (m_stk.size() > 0) begin
        m_out = m_stk.pop_back(); m_load = 1;
      end else begin
        m_load = 0; m_unf = 1;
      end
    end else begin
      m_load = 0;
    end
  endtask

  // Compare process: outputs settle after the falling edge, sampled on the rising edge.
  initial begin
    while (!done) begin
      @(posedge clk);
      if (!done) begin
        check("count",     32'(count),     32'(m_stk.size()));
        check("full",      32'(full),      32'(m_stk.size() == DEPTH));
        check("empty",     32'(empty),     32'(m_stk.size() == 0));
        check("wp_out",    32'(wp_out),    32'(m_out));
        check("wp_load",   32'(wp_load),   32'(m_load));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
      end
    end
  end

  // One clock of stimulus: drive after the rising edge, model after the falling edge.
  task automatic cycle(input bit f, input bit pu, input bit po, input int d);
    @(posedge clk); #1;
    flush = f; push = pu; pop = po; wp_in = WP_WIDTH'(d);
    @(negedge clk); #1;
    if (reset_n) model_update(f, pu, po, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic async_reset();
    @(posedge clk); #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_load",  32'(wp_load), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_load",  32'(wp_load), 32'd0);
    check("rst_out",   32'(wp_out), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_unf",   32'(underflow), 32'd0);

    // Call/return nesting 3,5,6
    cycle(0, 1, 0, 3); cycle(0, 1, 0, 5); cycle(0, 1, 0, 6);
    check("lifo_cnt3", 32'(count), 32'd3);
    cycle(0, 0, 1, 0);
    check("pop1_out", 32'(wp_out), 32'd6); check("pop1_ld", 32'(wp_load), 32'd1);
    check("pop1_cnt", 32'(count), 32'd2);
    cycle(0, 0, 1, 0);
    check("pop2_out", 32'(wp_out), 32'd5); check("pop2_ld", 32'(wp_load), 32'd1);
    cycle(0, 0, 1, 0);
    check("pop3_out", 32'(wp_out), 32'd3); check("pop3_ld", 32'(wp_load), 32'd1);
    check("pop3_empty", 32'(empty), 32'd1);
    idle(1);
    check("strobe_end", 32'(wp_load), 32'd0);

    // Fill then overflow
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, i);
    cycle(0, 1, 0, 2);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_cnt",  32'(count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    cycle(0, 0, 1, 0);
    check("ovf_pop", 32'(wp_out), 32'd7);

    // Underflow then flush
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_load", 32'(wp_load), 32'd0);
    check("unf_out",  32'(wp_out), 32'd7);
    cycle(1, 0, 0, 0);
    check("flush_unf", 32'(underflow), 32'd0);
    check("flush_cnt", 32'(count), 32'd0);

    // Simultaneous push/pop at empty and full
    cycle(0, 1, 1, 4);
    check("pp0_out", 32'(wp_out), 32'd4); check("pp0_ld", 32'(wp_load), 32'd1);
    check("pp0_cnt", 32'(count), 32'd0);
    check("pp0_flags", 32'({overflow, underflow}), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 7 - i);
    cycle(0, 1, 1, 4);
    check("pp8_out", 32'(wp_out), 32'd4); check("pp8_ld", 32'(wp_load), 32'd1);
    check("pp8_cnt", 32'(count), 32'd8);
    check("pp8_flags", 32'({overflow, underflow}), 32'd0);

    // Mid-cycle reset discards the pending strobe
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 1); cycle(0, 1, 0, 2);
    cycle(0, 0, 1, 0);
    check("pre_rst_ld", 32'(wp_load), 32'd1);
    async_reset();
    cycle(0, 0, 1, 0);
    check("post_rst_unf", 32'(underflow), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4) async_reset();
      else if (r < 30) cycle(1, 0, 0, 0);
      else cycle(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, (1 << WP_WIDTH) - 1)));
    end

    @(posedge clk); #1;
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/window_stack.md
Name: window_stack

Overview:
- Return-side companion to the SAYEH window pointer: saves the current window pointer on subroutine call and restores it on return.
- Provides a LIFO of saved window-pointer values.
- On a pop, drives the restored value plus a one-cycle load strobe into the window pointer's parallel-load path.
- Sits beside the window pointer in the datapath, is driven by the controller's call/return decode, and updates on the same falling clock edge as the rest of the datapath.

Parameters:
- WP_WIDTH, 3, width of a window-pointer value.
- DEPTH, 8, number of stack entries; must be a power of two.
- SP_WIDTH, 3, log2(DEPTH); the occupancy count is SP_WIDTH+1 bits wide.

Ports:
- clk  input  1  datapath clock; all state changes on negedge clk.
- reset_n  input  1  asynchronous, active-low reset.
- wp_in  input  WP_WIDTH  current window pointer value, captured on push.
- push  input  1  save wp_in (call).
- pop  input  1  restore the most recent saved value (return).
- flush  input  1  synchronous clear of stack and flags.
- wp_out  output  WP_WIDTH  restored window pointer value.
- wp_load  output  1  one-cycle strobe; the window pointer loads wp_out while this is high.
- count  output  SP_WIDTH+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH (combinational from count).
- empty  output  1  count == 0 (combinational from count).
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: reset_n low asynchronously forces the following, independent of clk:
  - count=0, wp_out=0, wp_load=0, overflow=0, underflow=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards any pending strobe.
- All registers update on negedge clk when reset_n is high.
- Priority on each edge: flush, then push/pop.
- flush=1:
  - count=0, overflow=0, underflow=0, wp_load=0.
  - push and pop are ignored on that edge.
- push only:
  - If count<DEPTH: mem[count]=wp_in, count=count+1.
  - Else: no write, count unchanged, overflow=1.
  - wp_load=0.
- pop only:
  - If count>0: wp_out=mem[count-1], count=count-1, wp_load=1.
  - Else: wp_out unchanged, wp_load=0, underflow=1.
- push and pop together (call immediately returned):
  - Net push-then-pop: wp_out=wp_in, wp_load=1.
  - count and memory unchanged.
  - No overflow or underflow in any occupancy state, including full and empty.
- Neither push nor pop: wp_load=0; all other state holds.
- Timing of the restore:
  - wp_load is high for exactly one clk period, from the pop edge to the next falling edge.
  - wp_out is valid from the same edge and holds until the next successful pop.
  - Back-to-back pops produce consecutive strobes with descending-depth values.
- Width rules:
  - wp_in is stored unmodified. No arithmetic is applied to window values; the offset add stays in the window pointer.
  - count never wraps; it saturates by refusing the operation.
- Sticky flags clear only on reset_n or flush.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, wp_load=0, wp_out=0, both flags 0.
- Push wp_in=3, then 5, then 6; pop three times on successive cycles -> wp_out=6,5,3 with wp_load high each cycle; count 3->0; empty=1 at end.
- Push 8 values 0..7, then a ninth push of 2 -> full=1, count=8, overflow=1; a subsequent pop returns 7 (the 2 was not stored).
- Pop on empty -> underflow=1, wp_load=0, wp_out unchanged. Then flush -> underflow=0, count=0.
- Simultaneous push=1, pop=1 with wp_in=4, at count=0 and again at count=8 -> wp_out=4, wp_load=1, count unchanged, no flags set.
- Push 2 values, assert reset_n low between clock edges -> count=0 and wp_load=0 immediately without a clock edge; next pop -> underflow=1.
